multicycle_main_control: RTL and testbench
==========================================

Name: multicycle_main_control

Overview:
- Multicycle main control FSM for the RV64 integer core subset: ld, sd, R-type add/sub/and/or, beq.
- Accepts one instruction per handshake and latches its opcode.
- Sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath enables plus the 2-bit ALUOp consumed by the ALU control decoder.
- Sits between the instruction register/fetch unit and the datapath; waits on data memory through a ready input.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  fetch unit presents an instruction.
- instr_ready  out  1  FSM accepts an instruction this cycle.
- opcode  in  7  instr[6:0]; sampled only on the accept cycle.
- zero  in  1  ALU zero flag; used in EXEC for beq.
- mem_ready  in  1  data memory completes the access this cycle.
- ir_write  out  1  latch instruction register (the accept cycle).
- alu_op  out  2  00 = ld/sd add, 01 = beq sub, 10 = R-type (funct decode).
- alu_src  out  1  1 = immediate operand B.
- mem_read  out  1  data memory read request.
- mem_write  out  1  data memory write request.
- mem_to_reg  out  1  1 = writeback from memory.
- reg_write  out  1  register file write enable.
- pc_write  out  1  PC update strobe, one pulse per retired instruction.
- pc_src  out  1  1 = branch target, 0 = PC+4; meaningful only with pc_write.
- illegal  out  1  one-cycle pulse for an unsupported opcode.
- retired  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (async, any state, including mid-MEM):
  - state = FETCH; latched opcode class = NONE; retired = 0.
  - All outputs 0 except instr_ready = 1, which asserts as FETCH takes effect.
- Opcode classes: 0110011 = RTYPE, 0000011 = LOAD, 0100011 = STORE, 1100011 = BRANCH; anything else = ILLEGAL.
- FETCH:
  - instr_ready = 1.
  - On instr_valid: ir_write = 1 (same cycle), latch class, go to DECODE.
  - Otherwise stay.
- DECODE:
  - One cycle, no datapath enables.
  - ILLEGAL goes to ERR; all other classes go to EXEC.
- EXEC, all outputs other than those below are 0:
  - RTYPE: alu_op = 10, alu_src = 0; go to WB.
  - LOAD/STORE: alu_op = 00, alu_src = 1; go to MEM.
  - BRANCH: alu_op = 01, alu_src = 0; pc_write = 1, pc_src = zero (combinational from the input this cycle); retire; go to FETCH.
- MEM:
  - LOAD holds mem_read = 1; STORE holds mem_write = 1. alu_op = 00 and alu_src = 1 are held.
  - No mem_ready: stay, requests stay asserted (no timeout).
  - mem_ready with LOAD: go to WB.
  - mem_ready with STORE: pc_write = 1, pc_src = 0, retire, go to FETCH.
- WB:
  - reg_write = 1, mem_to_reg = (class == LOAD), pc_write = 1, pc_src = 0.
  - Retire; go to FETCH.
- ERR:
  - illegal = 1 for one cycle; PC is not written; retired is unchanged.
  - Go to FETCH.
- Retire: retired increments by 1 on the retire cycle and wraps modulo 2^CNT_W (all-ones -> 0, no saturation).
- Latency from accept cycle to retire cycle inclusive:
  - beq: 3 cycles.
  - RTYPE: 4 cycles.
  - sd: 4 + wait cycles.
  - ld: 5 + wait cycles.
- Mutual exclusion:
  - mem_read and mem_write are never both high.
  - reg_write and mem_write are never both high.
  - instr_ready is high only in FETCH.
- Output timing: all outputs are decoded from state and latched class (Moore). The only exception is pc_src, which follows zero during EXEC of a BRANCH.
- Opcode stability: opcode changes outside the accept cycle have no effect.

Decomposition:
- Shared package core_ctrl_pkg:
  - Opcode constants OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH.
  - ALUOp encodings ALUOP_ADD = 00, ALUOP_BEQ = 01, ALUOP_FUNCT = 10.
  - State enum FETCH/DECODE/EXEC/MEM/WB/ERR and class enum NONE/RTYPE/LOAD/STORE/BRANCH/ILLEGAL.
- Sub-module opcode_classifier: purely combinational, opcode -> class. It is reused by the decode-stage assertions.

Test Plan:
- add: valid with opcode 0110011, mem_ready = 0. Required: ir_write at cycle 0; alu_op = 10 at cycle 2; reg_write = 1, mem_to_reg = 0, pc_write = 1 at cycle 3; retired 0 -> 1; instr_ready back at cycle 4.
- ld with mem_ready low for 2 cycles: mem_read high for exactly 3 cycles, alu_op = 00 and alu_src = 1 throughout; then WB with reg_write = 1, mem_to_reg = 1; retire at cycle 6.
- beq: zero = 1 in EXEC gives pc_write = 1, pc_src = 1 at cycle 2 and no reg_write. Repeat with zero = 0: pc_src = 0. retired increments both times.
- sd with mem_ready = 1 immediately: mem_write at cycle 3 with pc_write = 1; reg_write never asserts; mem_read stays 0.
- Illegal opcode 1111111: illegal pulses for 1 cycle at cycle 2; no pc_write; retired unchanged; next instruction accepted at cycle 3.
- Reset and wrap:
  - Assert rst_n low mid-MEM of an ld: mem_read drops asynchronously, retired = 0, FETCH resumes after release.
  - Force retired to all-ones with a short CNT_W = 4 build: the next retire gives 0.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the multicycle core control path: opcodes, ALUOp
// values, controller states and the opcode classes the controller acts on.
package core_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    ERR
  } state_e;

  typedef enum logic [2:0] {
    NONE,
    RTYPE,
    LOAD,
    STORE,
    BRANCH,
    ILLEGAL
  } class_e;

endpackage

// File: rtl/multicycle_main_control_opcode_classifier.sv
// Combinational opcode -> instruction class map. Anything outside the
// supported subset is reported as ILLEGAL.
module opcode_classifier
  import core_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output class_e     class_o
);

  // Exact match on the 7-bit major opcode.
  always_comb begin
    case (opcode_i)
      OP_RTYPE:  class_o = RTYPE;
      OP_LOAD:   class_o = LOAD;
      OP_STORE:  class_o = STORE;
      OP_BRANCH: class_o = BRANCH;
      default:   class_o = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle main control FSM: accepts one instruction per handshake,
// steps it through FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables.
// Outputs are Moore-decoded from state and latched class, except pc_src,
// which follows zero during EXEC of a branch.
module multicycle_main_control
  import core_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  class_e           class_q, class_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  class_e           op_class;

  opcode_classifier u_classifier (
    .opcode_i (opcode),
    .class_o  (op_class)
  );

  // State, latched class and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      class_q   <= NONE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      retired_q <= retired_d;
    end
  end

  // Next state and output decode; every retire cycle is exactly a pc_write cycle.
  always_comb begin
    state_d     = state_q;
    class_d     = class_q;
    instr_ready = 1'b0;
    ir_write    = 1'b0;
    alu_op      = ALUOP_ADD;
    alu_src     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_write = 1'b1;
          class_d  = op_class;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        state_d = (class_q == ILLEGAL) ? ERR : EXEC;
      end
      EXEC: begin
        case (class_q)
          RTYPE: begin
            alu_op  = ALUOP_FUNCT;
            state_d = WB;
          end
          LOAD, STORE: begin
            alu_op  = ALUOP_ADD;
            alu_src = 1'b1;
            state_d = MEM;
          end
          BRANCH: begin
            alu_op   = ALUOP_BEQ;
            pc_write = 1'b1;
            pc_src   = zero;
            state_d  = FETCH;
          end
          default: state_d = FETCH;
        endcase
      end
      MEM: begin
        alu_op    = ALUOP_ADD;
        alu_src   = 1'b1;
        mem_read  = (class_q == LOAD);
        mem_write = (class_q == STORE);
        if (mem_ready) begin
          if (class_q == LOAD) begin
            state_d = WB;
          end else begin
            pc_write = (class_q == STORE);
            state_d  = FETCH;
          end
        end
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (class_q == LOAD);
        pc_write   = 1'b1;
        state_d    = FETCH;
      end
      ERR: begin
        illegal = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    retired_d = pc_write ? retired_q + CNT_W'(1) : retired_q;
  end

  assign retired = retired_q;

  a_mem_excl: assert property (@(posedge clk) disable iff (!rst_n) !(mem_read && mem_write));
  a_wr_excl:  assert property (@(posedge clk) disable iff (!rst_n) !(reg_write && mem_write));
  a_decode_class: assert property (@(posedge clk) disable iff (!rst_n)
                                   ir_write |=> (class_q == $past(op_class)));
  a_decode_known: assert property (@(posedge clk) disable iff (!rst_n)
                                   (state_q == DECODE) |-> (class_q != NONE));

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: a transaction-level model expands each
// instruction into its per-cycle expected output vectors; one compare
// process checks both a 32-bit and a 4-bit counter build every cycle.
module tb_multicycle_main_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;

  logic        instr_ready, ir_write, alu_src, mem_read, mem_write;
  logic        mem_to_reg, reg_write, pc_write, pc_src, illegal;
  logic [1:0]  alu_op;
  logic [31:0] retired;

  logic        w4_instr_ready, w4_ir_write, w4_alu_src, w4_mem_read, w4_mem_write;
  logic        w4_mem_to_reg, w4_reg_write, w4_pc_write, w4_pc_src, w4_illegal;
  logic [1:0]  w4_alu_op;
  logic [3:0]  w4_retired;

  always #5 clk = ~clk;

  multicycle_main_control #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .zero(zero), .mem_ready(mem_ready), .ir_write(ir_write),
    .alu_op(alu_op), .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .pc_write(pc_write),
    .pc_src(pc_src), .illegal(illegal), .retired(retired)
  );

  multicycle_main_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(w4_instr_ready),
    .opcode(opcode), .zero(zero), .mem_ready(mem_ready), .ir_write(w4_ir_write),
    .alu_op(w4_alu_op), .alu_src(w4_alu_src), .mem_read(w4_mem_read),
    .mem_write(w4_mem_write), .mem_to_reg(w4_mem_to_reg), .reg_write(w4_reg_write),
    .pc_write(w4_pc_write), .pc_src(w4_pc_src), .illegal(w4_illegal),
    .retired(w4_retired)
  );

  typedef struct packed {
    logic        instr_ready;
    logic        ir_write;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic        pc_write;
    logic        pc_src;
    logic        illegal;
    logic [31:0] retired;
  } outv_t;

  typedef struct {
    string name;
    outv_t v;
  } exp_t;

  exp_t        expq[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] m_retired = '0;
  int unsigned mr_cnt = 0;
  int unsigned rw_cnt = 0;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [6:0] junk();
    return 7'($urandom);
  endfunction

  function automatic outv_t blank();
    outv_t v;
    v = '0;
    v.retired = m_retired;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Per-cycle compare of both builds against the model's vector.
  always @(negedge clk) begin : cmp
    exp_t  x;
    outv_t a;
    outv_t a4;
    outv_t r4;
    mr_cnt += 32'(mem_read);
    rw_cnt += 32'(reg_write);
    if (expq.size() > 0) begin
      x = expq.pop_front();
      a = {instr_ready, ir_write, alu_op, alu_src, mem_read, mem_write,
           mem_to_reg, reg_write, pc_write, pc_src, illegal, retired};
      a4 = {w4_instr_ready, w4_ir_write, w4_alu_op, w4_alu_src, w4_mem_read,
            w4_mem_write, w4_mem_to_reg, w4_reg_write, w4_pc_write, w4_pc_src,
            w4_illegal, {28'd0, w4_retired}};
      r4 = x.v;
      r4.retired = {28'd0, x.v.retired[3:0]};
      n_cmp++;
      if (a !== x.v) begin
        n_bad++;
        $display("FAIL %s: got %h, required %h", x.name, a, x.v);
      end
      n_cmp++;
      if (a4 !== r4) begin
        n_bad++;
        $display("FAIL %s(cnt4): got %h, required %h", x.name, a4, r4);
      end
    end
  end

  // One clock of stimulus plus its expected outputs; called at posedge+1.
  task automatic step(input string name, input logic v, input logic [6:0] op,
                      input logic z, input logic mr, input outv_t e);
    exp_t x;
    instr_valid = v;
    opcode      = op;
    zero        = z;
    mem_ready   = mr;
    x.name = name;
    x.v    = e;
    expq.push_back(x);
    @(posedge clk);
    #1;
    if (e.pc_write) m_retired++;
  endtask

  task automatic idle(input string name);
    outv_t e;
    e = blank();
    e.instr_ready = 1'b1;
    step(name, 1'b0, junk(), rb(), rb(), e);
  endtask

  // Expands one instruction into its cycle-by-cycle expected behaviour.
  task automatic do_instr(input string tag, input logic [6:0] op,
                          input int unsigned waits, input logic z);
    outv_t e;
    bit is_r, is_l, is_s, is_b;
    is_r = (op == 7'b0110011);
    is_l = (op == 7'b0000011);
    is_s = (op == 7'b0100011);
    is_b = (op == 7'b1100011);

    e = blank(); e.instr_ready = 1'b1; e.ir_write = 1'b1;
    step({tag, ".accept"}, 1'b1, op, rb(), rb(), e);
    e = blank();
    step({tag, ".decode"}, 1'b0, junk(), rb(), rb(), e);
    if (!(is_r || is_l || is_s || is_b)) begin
      e = blank(); e.illegal = 1'b1;
      step({tag, ".err"}, 1'b0, junk(), rb(), rb(), e);
      return;
    end
    e = blank();
    if (is_r) e.alu_op = 2'b10;
    if (is_l || is_s) begin e.alu_op = 2'b00; e.alu_src = 1'b1; end
    if (is_b) begin e.alu_op = 2'b01; e.pc_write = 1'b1; e.pc_src = z; end
    step({tag, ".exec"}, 1'b0, junk(), is_b ? z : rb(), rb(), e);
    if (is_b) return;
    if (is_l || is_s) begin
      for (int unsigned i = 0; i <= waits; i++) begin
        e = blank();
        e.alu_src   = 1'b1;
        e.mem_read  = is_l;
        e.mem_write = is_s;
        e.pc_write  = is_s && (i == waits);
        step({tag, ".mem"}, 1'b0, junk(), rb(), (i == waits), e);
      end
      if (is_s) return;
    end
    e = blank(); e.reg_write = 1'b1; e.mem_to_reg = is_l; e.pc_write = 1'b1;
    step({tag, ".wb"}, 1'b0, junk(), rb(), rb(), e);
  endtask

  initial begin
    outv_t e;
    rst_n = 1'b0; instr_valid = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.outs", 64'({instr_ready, ir_write, alu_op, alu_src, mem_read, mem_write,
                              mem_to_reg, reg_write, pc_write, pc_src, illegal}), 64'h800);
    check("reset.retired", 64'(retired), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_instr("add", 7'b0110011, 0, 1'b0);
    check("add.retired", 64'(retired), 64'd1);
    check("add.ready_c4", 64'(instr_ready), 64'd1);

    mr_cnt = 0;
    do_instr("ld", 7'b0000011, 2, 1'b0);
    check("ld.mem_read_cycles", 64'(mr_cnt), 64'd3);
    check("ld.retired", 64'(retired), 64'd2);

    do_instr("beq_z1", 7'b1100011, 0, 1'b1);
    do_instr("beq_z0", 7'b1100011, 0, 1'b0);
    check("beq.retired", 64'(retired), 64'd4);

    mr_cnt = 0; rw_cnt = 0;
    do_instr("sd", 7'b0100011, 0, 1'b0);
    check("sd.reg_write_cycles", 64'(rw_cnt), 64'd0);
    check("sd.mem_read_cycles", 64'(mr_cnt), 64'd0);
    check("sd.retired", 64'(retired), 64'd5);

    do_instr("ill", 7'b1111111, 0, 1'b0);
    check("ill.retired", 64'(retired), 64'd5);
    do_instr("add_after_ill", 7'b0110011, 0, 1'b0);
    check("add2.retired", 64'(retired), 64'd6);

    // Load interrupted by reset while waiting on memory.
    e = blank(); e.instr_ready = 1'b1; e.ir_write = 1'b1;
    step("ldr.accept", 1'b1, 7'b0000011, 1'b0, 1'b0, e);
    e = blank();
    step("ldr.decode", 1'b0, junk(), 1'b0, 1'b0, e);
    e = blank(); e.alu_src = 1'b1;
    step("ldr.exec", 1'b0, junk(), 1'b0, 1'b0, e);
    e = blank(); e.alu_src = 1'b1; e.mem_read = 1'b1;
    step("ldr.mem", 1'b0, junk(), 1'b0, 1'b0, e);
    instr_valid = 1'b0; mem_ready = 1'b0;
    #1;
    check("ldr.mem_read_pre", 64'(mem_read), 64'd1);
    rst_n = 1'b0;
    #1;
    check("ldr.mem_read_async", 64'(mem_read), 64'd0);
    check("ldr.retired_async", 64'(retired), 64'd0);
    check("ldr.ready_async", 64'(instr_ready), 64'd1);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_retired = '0;
    idle("post_reset.idle");

    for (int unsigned i = 0; i < 15; i++) do_instr("beq_loop", 7'b1100011, 0, 1'(i));
    check("cnt4.all_ones", 64'(w4_retired), 64'hF);
    do_instr("beq_wrap", 7'b1100011, 0, 1'b1);
    check("cnt4.wrap", 64'(w4_retired), 64'd0);
    check("cnt32.no_wrap", 64'(retired), 64'd16);
    do_instr("add_after_wrap", 7'b0110011, 0, 1'b0);
    check("cnt4.after_wrap", 64'(w4_retired), 64'd1);
    idle("final.idle");
    check("queue.drained", 64'(expq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
